result_bcd_converter: RTL

Sequential binary-to-BCD stage that sits directly downstream of the calculator's 8-bit arithmetic units (divider, multiplier, adder).
- Takes an 8-bit unsigned result and its error flag.
- Converts the result to three BCD digits with an iterative double-dabble (shift-and-add-3) engine, one bit per cycle.
- Presents registered digits to the display driver.
- Handles error indication and leading-zero blanking.

---
 rtl/calc_pkg.sv | 13 +
 rtl/bcd_add3.sv | 10 +
 rtl/result_bcd_converter.sv | 113 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path.
package calc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, ERR} state_t;

  localparam int DIGITS    = 3;
  localparam int IN_WIDTH  = 8;
  localparam int ITER      = 8;
  localparam int SCRATCH_W = 4 * DIGITS + IN_WIDTH;
  localparam int CNT_W     = $clog2(ITER);

  localparam logic [3:0] ERR_CODE_DEF   = 4'hE;
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: add 3 to a BCD field that is 5 or more.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) adjusted = digit + 4'd3;
  end
endmodule

// File: rtl/result_bcd_converter.sv
// Iterative 8-bit binary to 3-digit BCD converter with error display
// and optional leading-zero blanking.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter logic [3:0] ERR_CODE   = ERR_CODE_DEF,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF,
  parameter logic       BLANK_LZ   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] value,
  input  logic                error_in,
  output logic                ready,
  output logic                done,
  output logic [3:0]          bcd_hundreds,
  output logic [3:0]          bcd_tens,
  output logic [3:0]          bcd_ones,
  output logic                err_out
);
  state_t                 state, state_next;
  logic [SCRATCH_W-1:0]   scratch, scratch_next, adj, conv;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   load_digits, load_err;
  logic                   h_blank, t_blank;
  logic [3:0]             h_out, t_out;

  bcd_add3 u_add_h (.digit(scratch[19:16]), .adjusted(adj[19:16]));
  bcd_add3 u_add_t (.digit(scratch[15:12]), .adjusted(adj[15:12]));
  bcd_add3 u_add_o (.digit(scratch[11:8]),  .adjusted(adj[11:8]));
  assign adj[IN_WIDTH-1:0] = scratch[IN_WIDTH-1:0];
  assign conv = adj << 1;

  assign ready = (state == IDLE);

  // Blanking is evaluated on the final shifted value, so it applies at load time only.
  always_comb begin
    h_blank = BLANK_LZ && (conv[19:16] == 4'd0);
    t_blank = h_blank && (conv[15:12] == 4'd0);
    h_out   = h_blank ? BLANK_CODE : conv[19:16];
    t_out   = t_blank ? BLANK_CODE : conv[15:12];
  end

  always_comb begin
    state_next   = state;
    scratch_next = scratch;
    cnt_next     = cnt;
    load_digits  = 1'b0;
    load_err     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (error_in) begin
            state_next = ERR;
          end else begin
            scratch_next = {{(4 * DIGITS){1'b0}}, value};
            cnt_next     = '0;
            state_next   = SHIFT;
          end
        end
      end
      SHIFT: begin
        scratch_next = conv;
        cnt_next     = cnt + 1'b1;
        if (cnt == CNT_W'(ITER - 1)) begin
          load_digits = 1'b1;
          state_next  = IDLE;
        end
      end
      ERR: begin
        load_err   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch      <= '0;
      cnt          <= '0;
      done         <= 1'b0;
      err_out      <= 1'b0;
      bcd_hundreds <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
    end else begin
      scratch <= scratch_next;
      cnt     <= cnt_next;
      done    <= load_digits | load_err;
      if (load_digits) begin
        bcd_hundreds <= h_out;
        bcd_tens     <= t_out;
        bcd_ones     <= conv[11:8];
        err_out      <= 1'b0;
      end else if (load_err) begin
        bcd_hundreds <= ERR_CODE;
        bcd_tens     <= ERR_CODE;
        bcd_ones     <= ERR_CODE;
        err_out      <= 1'b1;
      end
    end
  end
endmodule
